// File: rtl/alu_operand_fetch_if.sv
// Bundle of signals between the decoder front end, the operand-fetch stage,
// the ALU that consumes operands, and the ALU write-back path.
interface alu_operand_fetch_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_A;
    logic [DATA_W-1:0] out_B;
    logic [2:0]        out_op;
    logic [3:0]        out_imm;
    logic [2:0]        out_last_flag;
    logic [3:0]        out_rd;
    logic              out_wr_en;
    logic              wb_en;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_flag_en;
    logic [2:0]        wb_flag;

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data, wb_flag_en, wb_flag,
        input  in_ready, out_valid, out_A, out_B, out_op, out_imm, out_last_flag, out_rd, out_wr_en
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data, wb_flag_en, wb_flag,
        output in_ready, out_valid, out_A, out_B, out_op, out_imm, out_last_flag, out_rd, out_wr_en
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: decodes an instruction, reads two sources from the
// register file (with write-back bypass) and presents a registered bundle to the ALU.
module alu_operand_fetch #(
    parameter int DATA_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_fetch_if.slave bus
);

    logic [DATA_W-1:0] rf_q [16];
    logic [2:0]        flag_q;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        imm_q, imm_d;
    logic [2:0]        lf_q, lf_d;
    logic [3:0]        rd_q, rd_d;
    logic              wr_en_q, wr_en_d;

    logic              in_ready_s;
    logic              accept_s;
    logic [3:0]        rs1_s;
    logic [3:0]        rs2_s;

    // R0 is hardwired to zero; an in-flight write to the same index wins over the array.
    function automatic logic [DATA_W-1:0] read_operand(
        input logic [3:0]        idx,
        input logic [DATA_W-1:0] array_val,
        input logic              wb_en,
        input logic [3:0]        wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] val;
        if (idx == 4'd0) begin
            val = {DATA_W{1'b0}};
        end else if (wb_en && (wb_rd == idx)) begin
            val = wb_data;
        end else begin
            val = array_val;
        end
        return val;
    endfunction

    assign rs1_s      = bus.in_instr[7:4];
    assign rs2_s      = bus.in_instr[3:0];
    assign in_ready_s = !out_valid_q || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Register file write port; writes proceed regardless of output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
        end else if (bus.wb_en && (bus.wb_rd != 4'd0)) begin
            rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Architectural flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 3'b000;
        end else if (bus.wb_flag_en) begin
            flag_q <= bus.wb_flag;
        end
    end

    // Output bundle next-state: load on accept, drain on consume, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        imm_d       = imm_q;
        lf_d        = lf_q;
        rd_d        = rd_q;
        wr_en_d     = wr_en_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            a_d         = read_operand(rs1_s, rf_q[rs1_s], bus.wb_en, bus.wb_rd, bus.wb_data);
            b_d         = read_operand(rs2_s, rf_q[rs2_s], bus.wb_en, bus.wb_rd, bus.wb_data);
            op_d        = bus.in_instr[15:13];
            wr_en_d     = bus.in_instr[12];
            rd_d        = bus.in_instr[11:8];
            imm_d       = bus.in_instr[3:0];
            if (bus.wb_flag_en) begin
                lf_d = bus.wb_flag;
            end else begin
                lf_d = flag_q;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output bundle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= {DATA_W{1'b0}};
            b_q         <= {DATA_W{1'b0}};
            op_q        <= 3'd0;
            imm_q       <= 4'd0;
            lf_q        <= 3'b000;
            rd_q        <= 4'd0;
            wr_en_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            lf_q        <= lf_d;
            rd_q        <= rd_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_A         = a_q;
    assign bus.out_B         = b_q;
    assign bus.out_op        = op_q;
    assign bus.out_imm       = imm_q;
    assign bus.out_last_flag = lf_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_wr_en     = wr_en_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_alu_operand_fetch;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_fetch_if #(.DATA_W(DW)) bus();

    alu_operand_fetch #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus the bundle the ALU should see.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
        logic [3:0]    imm;
        logic [2:0]    lf;
        logic [3:0]    rd;
        logic          wr;
    } bundle_t;

    logic [DW-1:0] m_rf [16];
    logic [2:0]    m_flag;
    bundle_t       m_out;

    function automatic logic [DW-1:0] model_read(input logic [3:0] idx);
        if (idx == 4'd0) return 16'h0000;
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
        return m_rf[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_rf[i] <= 16'h0000;
            m_flag <= 3'b000;
            m_out  <= '{default: 1'b0};
        end else begin
            if (bus.in_valid && (!m_out.v || bus.out_ready)) begin
                m_out <= '{v:   1'b1,
                           a:   model_read(bus.in_instr[7:4]),
                           b:   model_read(bus.in_instr[3:0]),
                           op:  bus.in_instr[15:13],
                           imm: bus.in_instr[3:0],
                           lf:  (bus.wb_flag_en ? bus.wb_flag : m_flag),
                           rd:  bus.in_instr[11:8],
                           wr:  bus.in_instr[12]};
            end else if (bus.out_ready) begin
                m_out.v <= 1'b0;
            end
            if (bus.wb_en && bus.wb_rd != 4'd0) m_rf[bus.wb_rd] <= bus.wb_data;
            if (bus.wb_flag_en) m_flag <= bus.wb_flag;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_out.v));
        chk("in_ready", 32'(bus.in_ready), 32'(!m_out.v || bus.out_ready));
        if (m_out.v) begin
            chk("out_A", 32'(bus.out_A), 32'(m_out.a));
            chk("out_B", 32'(bus.out_B), 32'(m_out.b));
            chk("out_op", 32'(bus.out_op), 32'(m_out.op));
            chk("out_imm", 32'(bus.out_imm), 32'(m_out.imm));
            chk("out_last_flag", 32'(bus.out_last_flag), 32'(m_out.lf));
            chk("out_rd", 32'(bus.out_rd), 32'(m_out.rd));
            chk("out_wr_en", 32'(bus.out_wr_en), 32'(m_out.wr));
        end
    end

    task automatic step(input logic iv, input logic [15:0] ins, input logic ordy,
                        input logic wbe, input logic [3:0] wrd, input logic [15:0] wd,
                        input logic wfe, input logic [2:0] wf);
        bus.in_valid   = iv;
        bus.in_instr   = ins;
        bus.out_ready  = ordy;
        bus.wb_en      = wbe;
        bus.wb_rd      = wrd;
        bus.wb_data    = wd;
        bus.wb_flag_en = wfe;
        bus.wb_flag    = wf;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_instr   = 16'h0000;
        bus.out_ready  = 1'b0;
        bus.wb_en      = 1'b0;
        bus.wb_rd      = 4'd0;
        bus.wb_data    = 16'h0000;
        bus.wb_flag_en = 1'b0;
        bus.wb_flag    = 3'b000;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_A", 32'(bus.out_A), 32'd0);
        chk("reset_last_flag", 32'(bus.out_last_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset mid-stall: write R3 and flags, hold a bundle, then assert reset.
        step(1'b0, 16'h0000, 1'b1, 1'b1, 4'd3, 16'h1234, 1'b1, 3'b101);
        step(1'b1, 16'h0033, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        chk("pre_rst_A", 32'(bus.out_A), 32'h1234);
        chk("pre_rst_flag", 32'(bus.out_last_flag), 32'd5);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 16'h0033, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        chk("post_rst_R3", 32'(bus.out_A), 32'h0000);
        chk("post_rst_flag", 32'(bus.out_last_flag), 32'd0);

        // Basic fetch.
        step(1'b0, 16'h0000, 1'b1, 1'b1, 4'd1, 16'h00FF, 1'b0, 3'b000);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 4'd2, 16'h0F0F, 1'b0, 3'b000);
        step(1'b1, 16'h3312, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        chk("basic_A", 32'(bus.out_A), 32'h00FF);
        chk("basic_B", 32'(bus.out_B), 32'h0F0F);
        chk("basic_op", 32'(bus.out_op), 32'd1);
        chk("basic_imm", 32'(bus.out_imm), 32'h2);
        chk("basic_rd", 32'(bus.out_rd), 32'd3);
        chk("basic_wr_en", 32'(bus.out_wr_en), 32'd1);

        // R0 stays zero even with a concurrent write to it.
        step(1'b1, 16'h2000, 1'b1, 1'b1, 4'd0, 16'hBEEF, 1'b0, 3'b000);
        chk("r0_A", 32'(bus.out_A), 32'h0000);
        chk("r0_B", 32'(bus.out_B), 32'h0000);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        chk("r0_later", 32'(bus.out_A), 32'h0000);

        // Write-back bypass of data and flags.
        step(1'b1, 16'h4055, 1'b1, 1'b1, 4'd5, 16'hA5A5, 1'b1, 3'b011);
        chk("bypass_A", 32'(bus.out_A), 32'hA5A5);
        chk("bypass_B", 32'(bus.out_B), 32'hA5A5);
        chk("bypass_flag", 32'(bus.out_last_flag), 32'd3);

        // Backpressure for three cycles, then drain-and-accept at one edge.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h6712, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_A", 32'(bus.out_A), 32'hA5A5);
            chk("stall_op", 32'(bus.out_op), 32'd2);
        end
        step(1'b1, 16'h6712, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        chk("drain_op", 32'(bus.out_op), 32'd3);
        chk("drain_A", 32'(bus.out_A), 32'h00FF);
        chk("drain_B", 32'(bus.out_B), 32'h0F0F);
        chk("drain_rd", 32'(bus.out_rd), 32'd7);

        // Streaming: 20 random instructions, no bubbles allowed.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'($urandom()), 1'b1, 1'($urandom()), 4'($urandom()),
                 16'($urandom()), 1'($urandom()), 3'($urandom()));
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
        end

        // Random traffic with random stalls and write-backs.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(1, 0)), 16'($urandom()), 1'($urandom_range(1, 0)),
                 1'($urandom()), 4'($urandom()), 16'($urandom()),
                 1'($urandom()), 3'($urandom()));
        end

        step(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 3'b000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch stage directly upstream of the ALU. It decodes a 16-bit instruction and reads two source registers from a 16 x DATA_W register file. It supplies the ALU's A, B, op, imm and lastFlag inputs from a registered output stage with a valid/ready handshake. It also owns the architectural register file and the 3-bit flag register, both written back from the ALU result path.

## Interface
- DATA_W, 16, register and operand width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction present on in_instr
- in_ready  output  1  stage accepts the instruction this cycle
- in_instr  input  16  fields: [15:13] op, [12] wr_en, [11:8] rd, [7:4] rs1, [3:0] rs2 / imm
- out_valid  output  1  operand bundle valid
- out_ready  input  1  ALU consumes the bundle this cycle
- out_A  output  DATA_W  value of R[rs1]
- out_B  output  DATA_W  value of R[rs2]
- out_op  output  3  ALU operation code
- out_imm  output  4  in_instr[3:0], passed through raw
- out_last_flag  output  3  current flag register value, drives ALU lastFlag
- out_rd  output  4  destination register index
- out_wr_en  output  1  result is to be written back
- wb_en  input  1  write wb_data to R[wb_rd]
- wb_rd  input  4  write-back index
- wb_data  input  DATA_W  write-back data
- wb_flag_en  input  1  load wb_flag into the flag register
- wb_flag  input  3  flags produced by the ALU

## Operation
- Register file R0..R15:
  - R0 reads as 0 at all times.
  - Writes to R0 are discarded.
  - R1..R15 are written on a rising clk edge when wb_en=1.
- Flag register (3 bits) loads wb_flag on a rising edge when wb_flag_en=1. Otherwise it holds.
- Handshake and output register:
  - in_ready = !out_valid || out_ready, combinational.
  - Accept = in_valid && in_ready.
  - On accept, the output register loads all out_* fields and sets out_valid=1.
  - If out_ready=1 and there is no accept, out_valid clears.
  - If out_valid=1 and out_ready=0, every out_* field holds stable.
- Write-back bypass on accept:
  - If wb_en=1 and wb_rd==rs1 and rs1!=0, out_A takes wb_data instead of the array value. out_B follows the same rule with rs2.
  - If wb_flag_en=1, out_last_flag takes wb_flag.
- out_last_flag is captured at accept time only. It does not track later flag writes while the bundle is held.
- Read and write are independent: a write-back is always performed, whether or not a stall is in progress.

## Timing
- Reset (rst_n=0, asynchronous assertion) forces the following, held until the first rising edge after rst_n=1:
  - out_valid=0
  - out_A=0, out_B=0, out_op=0, out_imm=0, out_rd=0, out_wr_en=0
  - out_last_flag=0
  - flag register=0
  - R1..R15=0
- Consequently, in_ready=1 during reset.
- Latency: an instruction accepted at edge N appears on the out_* ports after edge N.
- Throughput is one instruction per cycle while out_ready=1.
- Back-to-back accepts with out_ready held at 1 produce no bubble.
- Simultaneous accept and out_ready in the same cycle: the old bundle is consumed and the new bundle is loaded at the same edge.
- Simultaneous wb_en to rd=k and accept reading k: the new value is used through the bypass. The array is also updated at that edge.
- Reset asserted mid-stall: the held bundle is dropped and out_valid=0 immediately. No bundle is replayed after reset.

## Test plan
- Reset: write R3=0x1234 with flags=3'b101, then pulse rst_n low mid-cycle. Required response: out_valid=0 asynchronously. After release, reading R3 returns 0x0000 and out_last_flag=3'b000.
- Basic fetch: write R1=0x00FF and R2=0x0F0F, then issue instr 16'h3312 (op=1, wr_en=1, rd=3, rs1=1, rs2=2). Required response on the next cycle: out_A=0x00FF, out_B=0x0F0F, out_op=3'd1, out_imm=4'h2, out_rd=3, out_wr_en=1.
- R0: wb_en with wb_rd=0 and wb_data=0xBEEF, in the same cycle as an accept reading rs1=0 and rs2=0. Required response: out_A=0, out_B=0, and a later read of R0 is still 0.
- Bypass: wb_en with wb_rd=5 and wb_data=0xA5A5, plus wb_flag_en with wb_flag=3'b011, in the same cycle as an accept with rs1=5 and rs2=5. Required response: out_A=out_B=0xA5A5 and out_last_flag=3'b011.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Required response: in_ready=0 and the out_* fields are unchanged for all 3 cycles. Raising out_ready=1 drains the held bundle and accepts the pending instruction at the same edge.
- Streaming: 20 random instructions with out_ready=1 throughout. Required response: 20 consecutive valid bundles with no bubbles, each matching a reference register model.
